// File: rtl/dispatch_queue_if.sv
`default_nettype none
// ============================================================================
// Module  : dispatch_queue_if
// Brief   : Enqueue, CDB snoop and issue signals of the dispatch queue.
// Revision: 1.0
// ============================================================================
interface dispatch_queue_if #(
   parameter int DEPTH   = 8,
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 5,
   parameter int OP_W    = 6,
   parameter int NUM_CDB = 2
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                      flush;
   logic                      enq_valid;
   logic                      enq_ready;
   logic [1:0]                enq_class;
   logic [OP_W-1:0]           enq_op;
   logic [DATA_W-1:0]         enq_addr;
   logic [DATA_W-1:0]         enq_imm;
   logic [TAG_W-1:0]          enq_tag_o;
   logic [TAG_W-1:0]          enq_tag_t;
   logic [DATA_W-1:0]         enq_data_o;
   logic [DATA_W-1:0]         enq_data_t;
   logic [TAG_W-1:0]          enq_tag_w;
   logic [NUM_CDB-1:0]        cdb_valid;
   logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
   logic [NUM_CDB*DATA_W-1:0] cdb_data;
   logic                      alu_ready;
   logic                      br_ready;
   logic                      ls_ready;
   logic                      alu_en;
   logic                      br_en;
   logic                      ls_en;
   logic [OP_W-1:0]           iss_op;
   logic [DATA_W-1:0]         iss_addr;
   logic [DATA_W-1:0]         iss_imm;
   logic [DATA_W-1:0]         iss_data_o;
   logic [DATA_W-1:0]         iss_data_t;
   logic [TAG_W-1:0]          iss_tag_o;
   logic [TAG_W-1:0]          iss_tag_t;
   logic [TAG_W-1:0]          iss_tag_w;
   logic [CNT_W-1:0]          count;

   modport slave (
      input  flush, enq_valid, enq_class, enq_op, enq_addr, enq_imm,
             enq_tag_o, enq_tag_t, enq_data_o, enq_data_t, enq_tag_w,
             cdb_valid, cdb_tag, cdb_data, alu_ready, br_ready, ls_ready,
      output enq_ready, alu_en, br_en, ls_en, iss_op, iss_addr, iss_imm,
             iss_data_o, iss_data_t, iss_tag_o, iss_tag_t, iss_tag_w, count
   );

   modport master (
      output flush, enq_valid, enq_class, enq_op, enq_addr, enq_imm,
             enq_tag_o, enq_tag_t, enq_data_o, enq_data_t, enq_tag_w,
             cdb_valid, cdb_tag, cdb_data, alu_ready, br_ready, ls_ready,
      input  enq_ready, alu_en, br_en, ls_en, iss_op, iss_addr, iss_imm,
             iss_data_o, iss_data_t, iss_tag_o, iss_tag_t, iss_tag_w, count
   );
endinterface
`default_nettype wire

// File: rtl/dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module  : dispatch_queue
// Brief   : In-order dispatch queue with CDB operand snooping and issue.
// Revision: 1.0
// ============================================================================
module dispatch_queue #(
   parameter int DEPTH   = 8,
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 5,
   parameter int OP_W    = 6,
   parameter int NUM_CDB = 2
) (
   input  logic            clk,
   input  logic            rst,
   dispatch_queue_if.slave dq
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic              valid;
      logic [1:0]        cls;
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] imm;
      logic [TAG_W-1:0]  tag_o;
      logic [TAG_W-1:0]  tag_t;
      logic [DATA_W-1:0] data_o;
      logic [DATA_W-1:0] data_t;
      logic [TAG_W-1:0]  tag_w;
   } entry_t;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] data_o;
      logic [DATA_W-1:0] data_t;
      logic [TAG_W-1:0]  tag_o;
      logic [TAG_W-1:0]  tag_t;
      logic [TAG_W-1:0]  tag_w;
   } iss_t;

   entry_t           ent_q [DEPTH];
   entry_t           ent_d [DEPTH];
   entry_t           w_snp [DEPTH];
   entry_t           w_new;
   entry_t           w_head;
   iss_t             iss_q, iss_d;
   logic [2:0]       en_q, en_d;
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             w_head_rdy, w_do_iss, w_do_enq, w_enq_rdy;

   // Descending scan so the lowest-index matching channel is applied last.
   function automatic logic [TAG_W+DATA_W-1:0] snoop(
      input logic [TAG_W-1:0]          tag,
      input logic [DATA_W-1:0]         data,
      input logic [NUM_CDB-1:0]        cv,
      input logic [NUM_CDB*TAG_W-1:0]  ct,
      input logic [NUM_CDB*DATA_W-1:0] cd
   );
      logic [TAG_W+DATA_W-1:0] r;
      r = {tag, data};
      for (int c = NUM_CDB - 1; c >= 0; c--) begin
         if (tag != '0 && cv[c] && ct[c*TAG_W +: TAG_W] == tag)
            r = {{TAG_W{1'b0}}, cd[c*DATA_W +: DATA_W]};
      end
      return r;
   endfunction

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_snp[i] = ent_q[i];
         {w_snp[i].tag_o, w_snp[i].data_o} = snoop(ent_q[i].tag_o, ent_q[i].data_o,
                                                   dq.cdb_valid, dq.cdb_tag, dq.cdb_data);
         {w_snp[i].tag_t, w_snp[i].data_t} = snoop(ent_q[i].tag_t, ent_q[i].data_t,
                                                   dq.cdb_valid, dq.cdb_tag, dq.cdb_data);
      end
      w_new.valid = 1'b1;
      w_new.cls   = dq.enq_class;
      w_new.op    = dq.enq_op;
      w_new.addr  = dq.enq_addr;
      w_new.imm   = dq.enq_imm;
      w_new.tag_w = dq.enq_tag_w;
      {w_new.tag_o, w_new.data_o} = snoop(dq.enq_tag_o, dq.enq_data_o,
                                          dq.cdb_valid, dq.cdb_tag, dq.cdb_data);
      {w_new.tag_t, w_new.data_t} = snoop(dq.enq_tag_t, dq.enq_data_t,
                                          dq.cdb_valid, dq.cdb_tag, dq.cdb_data);
   end

   assign w_head = w_snp[head_q];

   always_comb begin
      case (w_head.cls)
         2'd0:    w_head_rdy = dq.alu_ready;
         2'd1:    w_head_rdy = dq.br_ready;
         2'd2:    w_head_rdy = dq.ls_ready;
         default: w_head_rdy = 1'b0;
      endcase
   end

   assign w_enq_rdy = (count_q < CNT_W'(DEPTH));
   assign w_do_iss  = !dq.flush && w_head.valid && w_head_rdy;
   assign w_do_enq  = !dq.flush && dq.enq_valid && w_enq_rdy && (dq.enq_class != 2'd3);

   always_comb begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = w_snp[i];
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (w_do_iss) begin
         ent_d[head_q].valid = 1'b0;
         head_d = head_q + 1'b1;
      end
      if (w_do_enq) begin
         ent_d[tail_q] = w_new;
         tail_d = tail_q + 1'b1;
      end
      count_d = count_q + CNT_W'(w_do_enq) - CNT_W'(w_do_iss);
      if (dq.flush) begin
         for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_comb begin
      iss_d = iss_q;
      en_d  = 3'b000;
      if (w_do_iss) begin
         iss_d.op     = w_head.op;
         iss_d.addr   = w_head.addr;
         iss_d.imm    = w_head.imm;
         iss_d.data_o = w_head.data_o;
         iss_d.data_t = w_head.data_t;
         iss_d.tag_o  = w_head.tag_o;
         iss_d.tag_t  = w_head.tag_t;
         iss_d.tag_w  = w_head.tag_w;
         case (w_head.cls)
            2'd0:    en_d = 3'b001;
            2'd1:    en_d = 3'b010;
            2'd2:    en_d = 3'b100;
            default: en_d = 3'b000;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         en_q    <= 3'b000;
         iss_q   <= '0;
         for (int i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         en_q    <= en_d;
         iss_q   <= iss_d;
         ent_q   <= ent_d;
      end
   end

   assign dq.enq_ready  = w_enq_rdy;
   assign dq.count      = count_q;
   assign dq.alu_en     = en_q[0];
   assign dq.br_en      = en_q[1];
   assign dq.ls_en      = en_q[2];
   assign dq.iss_op     = iss_q.op;
   assign dq.iss_addr   = iss_q.addr;
   assign dq.iss_imm    = iss_q.imm;
   assign dq.iss_data_o = iss_q.data_o;
   assign dq.iss_data_t = iss_q.data_t;
   assign dq.iss_tag_o  = iss_q.tag_o;
   assign dq.iss_tag_t  = iss_q.tag_t;
   assign dq.iss_tag_w  = iss_q.tag_w;
endmodule
`default_nettype wire

// File: tb/tb_dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_dispatch_queue
// Brief   : Directed vector bench for dispatch_queue.
// Revision: 1.0
// ============================================================================
module tb_dispatch_queue;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   dispatch_queue_if #(.DEPTH(8), .DATA_W(32), .TAG_W(5), .OP_W(6), .NUM_CDB(2)) bus ();

   dispatch_queue #(.DEPTH(8), .DATA_W(32), .TAG_W(5), .OP_W(6), .NUM_CDB(2)) u_dut (
      .clk (clk),
      .rst (rst),
      .dq  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0] en;
   assign en = {bus.ls_en, bus.br_en, bus.alu_en};

   typedef struct {
      logic [1:0]  cls;
      logic [4:0]  tag_o, tag_t;
      logic [31:0] data_o, data_t;
      logic [1:0]  cdb_v;
      logic [4:0]  ct0, ct1;
      logic [31:0] cd0, cd1;
      logic [2:0]  e_en;
      logic [4:0]  e_tag_o, e_tag_t;
      logic [31:0] e_data_o, e_data_t;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      bus.flush      = 1'b0;
      bus.enq_valid  = 1'b0;
      bus.enq_class  = 2'd0;
      bus.enq_op     = '0;
      bus.enq_addr   = '0;
      bus.enq_imm    = '0;
      bus.enq_tag_o  = '0;
      bus.enq_tag_t  = '0;
      bus.enq_data_o = '0;
      bus.enq_data_t = '0;
      bus.enq_tag_w  = '0;
      bus.cdb_valid  = '0;
      bus.cdb_tag    = '0;
      bus.cdb_data   = '0;
      bus.alu_ready  = 1'b1;
      bus.br_ready   = 1'b1;
      bus.ls_ready   = 1'b1;
   endtask

   task automatic drive_enq(input logic [1:0] cls, input logic [31:0] addr);
      bus.enq_valid  = 1'b1;
      bus.enq_class  = cls;
      bus.enq_addr   = addr;
      bus.enq_op     = addr[5:0];
      bus.enq_imm    = ~addr;
      bus.enq_tag_o  = '0;
      bus.enq_tag_t  = '0;
      bus.enq_data_o = '0;
      bus.enq_data_t = '0;
      bus.enq_tag_w  = 5'd1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      idle();
      rst = 1'b1;
      repeat (2) step();
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_ready", 32'(bus.enq_ready), 1);
      chk("rst_en", 32'(en), 0);
      chk("rst_data_o", bus.iss_data_o, 0);
      chk("rst_tag_w", 32'(bus.iss_tag_w), 0);
      rst = 1'b0;
      step();

      //            cls   tag_o  tag_t  data_o  data_t   cdbv   ct0    ct1    cd0     cd1     en      etag_o etag_t edata_o edata_t
      vecs[0] = '{2'd0, 5'd0, 5'd0, 32'h5, 32'h7,  2'b00, 5'd0, 5'd0, 32'h0,  32'h0,  3'b001, 5'd0, 5'd0, 32'h5,  32'h7};
      vecs[1] = '{2'd0, 5'd2, 5'd4, 32'h1, 32'h1,  2'b01, 5'd4, 5'd0, 32'h9,  32'h0,  3'b001, 5'd2, 5'd0, 32'h1,  32'h9};
      vecs[2] = '{2'd1, 5'd6, 5'd0, 32'h0, 32'h33, 2'b11, 5'd6, 5'd6, 32'h11, 32'h22, 3'b010, 5'd0, 5'd0, 32'h11, 32'h33};
      vecs[3] = '{2'd2, 5'd0, 5'd7, 32'h3, 32'h44, 2'b11, 5'd0, 5'd7, 32'hFF, 32'h55, 3'b100, 5'd0, 5'd0, 32'h3,  32'h55};
      vecs[4] = '{2'd2, 5'd5, 5'd5, 32'hA, 32'hB,  2'b10, 5'd5, 5'd8, 32'h99, 32'h66, 3'b100, 5'd5, 5'd5, 32'hA,  32'hB};

      for (int v = 0; v < 5; v++) begin
         drive_enq(vecs[v].cls, 32'h1000 + 32'(v));
         bus.enq_tag_o  = vecs[v].tag_o;
         bus.enq_tag_t  = vecs[v].tag_t;
         bus.enq_data_o = vecs[v].data_o;
         bus.enq_data_t = vecs[v].data_t;
         bus.cdb_valid  = vecs[v].cdb_v;
         bus.cdb_tag    = {vecs[v].ct1, vecs[v].ct0};
         bus.cdb_data   = {vecs[v].cd1, vecs[v].cd0};
         step();
         bus.enq_valid = 1'b0;
         bus.cdb_valid = '0;
         chk($sformatf("v%0d_nobypass_en", v), 32'(en), 0);
         chk($sformatf("v%0d_count1", v), 32'(bus.count), 1);
         step();
         chk($sformatf("v%0d_en", v), 32'(en), 32'(vecs[v].e_en));
         chk($sformatf("v%0d_tag_o", v), 32'(bus.iss_tag_o), 32'(vecs[v].e_tag_o));
         chk($sformatf("v%0d_tag_t", v), 32'(bus.iss_tag_t), 32'(vecs[v].e_tag_t));
         chk($sformatf("v%0d_data_o", v), bus.iss_data_o, vecs[v].e_data_o);
         chk($sformatf("v%0d_data_t", v), bus.iss_data_t, vecs[v].e_data_t);
         chk($sformatf("v%0d_addr", v), bus.iss_addr, 32'h1000 + 32'(v));
         chk($sformatf("v%0d_imm", v), bus.iss_imm, ~(32'h1000 + 32'(v)));
         chk($sformatf("v%0d_tag_w", v), 32'(bus.iss_tag_w), 1);
         chk($sformatf("v%0d_count0", v), 32'(bus.count), 0);
         step();
         chk($sformatf("v%0d_en_off", v), 32'(en), 0);
      end

      // Reserved class is consumed but never stored.
      drive_enq(2'd3, 32'h33);
      chk("c3_ready", 32'(bus.enq_ready), 1);
      step();
      bus.enq_valid = 1'b0;
      chk("c3_count", 32'(bus.count), 0);
      step();
      chk("c3_en", 32'(en), 0);

      // Branch head waits; operand resolves while stored.
      bus.br_ready = 1'b0;
      drive_enq(2'd1, 32'h300);
      bus.enq_tag_o = 5'd3;
      step();
      bus.enq_valid = 1'b0;
      repeat (2) step();
      chk("br_stall_count", 32'(bus.count), 1);
      chk("br_stall_en", 32'(en), 0);
      bus.cdb_valid = 2'b10;
      bus.cdb_tag   = {5'd3, 5'd0};
      bus.cdb_data  = {32'hDEAD, 32'h0};
      step();
      bus.cdb_valid = '0;
      chk("br_snoop_en", 32'(en), 0);
      bus.br_ready = 1'b1;
      step();
      chk("br_en", 32'(en), 32'b010);
      chk("br_tag_o", 32'(bus.iss_tag_o), 0);
      chk("br_data_o", bus.iss_data_o, 32'hDEAD);
      step();
      chk("br_en_off", 32'(en), 0);

      // Fill, reject one at full while head issues, then drain in order.
      bus.ls_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive_enq(2'd2, 32'(i));
         step();
      end
      bus.enq_valid = 1'b0;
      chk("full_count", 32'(bus.count), 8);
      chk("full_ready", 32'(bus.enq_ready), 0);
      drive_enq(2'd2, 32'd99);
      bus.ls_ready = 1'b1;
      step();
      bus.enq_valid = 1'b0;
      chk("drain0_en", 32'(en), 32'b100);
      chk("drain0_addr", bus.iss_addr, 0);
      chk("drain0_count", 32'(bus.count), 7);
      for (int i = 1; i < 8; i++) begin
         step();
         chk($sformatf("drain%0d_en", i), 32'(en), 32'b100);
         chk($sformatf("drain%0d_addr", i), bus.iss_addr, 32'(i));
      end
      chk("drain_count", 32'(bus.count), 0);
      step();
      chk("drain_en_off", 32'(en), 0);
      chk("drain_extra_count", 32'(bus.count), 0);

      // In-order blocking: stalled LS head holds back a ready ALU entry.
      bus.ls_ready = 1'b0;
      drive_enq(2'd2, 32'h100);
      step();
      drive_enq(2'd0, 32'h200);
      step();
      bus.enq_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("block%0d_en", i), 32'(en), 0);
         step();
      end
      chk("block_count", 32'(bus.count), 2);
      bus.ls_ready = 1'b1;
      step();
      chk("unblk_ls_en", 32'(en), 32'b100);
      chk("unblk_ls_addr", bus.iss_addr, 32'h100);
      step();
      chk("unblk_alu_en", 32'(en), 32'b001);
      chk("unblk_alu_addr", bus.iss_addr, 32'h200);
      step();

      // Flush with a concurrent enqueue.
      bus.alu_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive_enq(2'd0, 32'h500 + 32'(i));
         step();
      end
      chk("pre_flush_count", 32'(bus.count), 5);
      drive_enq(2'd0, 32'hBAD);
      bus.flush     = 1'b1;
      bus.alu_ready = 1'b1;
      step();
      bus.flush     = 1'b0;
      bus.enq_valid = 1'b0;
      chk("flush_count", 32'(bus.count), 0);
      chk("flush_en", 32'(en), 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("post_flush%0d_en", i), 32'(en), 0);
      end
      drive_enq(2'd0, 32'h777);
      step();
      drive_enq(2'd0, 32'h778);
      chk("new_enq_en", 32'(en), 0);
      chk("new_enq_count", 32'(bus.count), 1);
      step();
      bus.enq_valid = 1'b0;
      chk("simul_en", 32'(en), 32'b001);
      chk("simul_addr", bus.iss_addr, 32'h777);
      chk("simul_count", 32'(bus.count), 1);
      step();
      chk("last_en", 32'(en), 32'b001);
      chk("last_addr", bus.iss_addr, 32'h778);
      chk("last_count", 32'(bus.count), 0);
      step();
      chk("last_en_off", 32'(en), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/dispatch_queue.md
Name: dispatch_queue

Overview:
- Parametrised in-order dispatch queue between the decoder/renamer and the three reservation stations: ALU RS, Branch RS and LS buffer.
- Buffers up to DEPTH renamed instructions.
- Snoops NUM_CDB result broadcast buses so that waiting operands resolve while queued.
- Issues the head entry to its target station only when that station is ready, and flushes everything on a misprediction.

Parameters:
- DEPTH, 8, queue entries; power of two, ≥2.
- DATA_W, 32, operand/immediate/address width.
- TAG_W, 5, rename tag width; tag value 0 means "free / value valid".
- OP_W, 6, opcode width.
- NUM_CDB, 2, number of result broadcast channels snooped.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  misprediction flush; highest priority.
- enq_valid  in  1  decoder presents an instruction.
- enq_ready  out  1  queue can accept; equals (count < DEPTH).
- enq_class  in  2  target: 0=ALU, 1=Branch, 2=LS, 3=reserved (dropped, never stored).
- enq_op  in  OP_W  opcode.
- enq_addr  in  DATA_W  instruction address.
- enq_imm  in  DATA_W  selected immediate.
- enq_tag_o / enq_tag_t  in  TAG_W each  source tags.
- enq_data_o / enq_data_t  in  DATA_W each  source values, used when the matching tag is 0.
- enq_tag_w  in  TAG_W  destination tag; 0 for branches.
- cdb_valid  in  NUM_CDB  per-channel broadcast valid.
- cdb_tag  in  NUM_CDB*TAG_W  channel i at bits [i*TAG_W +: TAG_W].
- cdb_data  in  NUM_CDB*DATA_W  channel i at bits [i*DATA_W +: DATA_W].
- alu_ready / br_ready / ls_ready  in  1 each  station can take one entry this cycle.
- alu_en / br_en / ls_en  out  1 each  registered one-cycle issue pulse; at most one high per cycle.
- iss_op  out  OP_W  registered issue field.
- iss_addr, iss_imm, iss_data_o, iss_data_t  out  DATA_W each  registered issue fields.
- iss_tag_o, iss_tag_t, iss_tag_w  out  TAG_W each  registered issue fields.
- count  out  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset (rst high at a clk edge):
  - head, tail and count go to 0.
  - alu_en, br_en and ls_en go to 0.
  - All iss_* fields go to 0.
  - All entry valid bits are cleared.
- Flush (flush high at an edge, rst low):
  - Same clearing as reset, except the iss_* data fields may hold their old values.
  - An enqueue offered in the same cycle is discarded.
  - No issue happens at that edge.
  - *_en is 0 in the following cycle.
- Enqueue:
  - Occurs at an edge when enq_valid and enq_ready are both high and enq_class != 3.
  - The entry is written at tail, tail increments modulo DEPTH, and count increments.
  - Class 3 is consumed (handshake completes) but not stored.
- Same-cycle CDB capture on enqueue:
  - For each source with tag != 0, if any cdb_valid[i] has cdb_tag[i] equal to that tag, store cdb_data[i] and store the tag as 0.
  - If several channels match, the lowest index wins.
- Snooping in storage:
  - Each edge, every valid entry applies the same capture rule to both of its source tags.
- Issue:
  - Occurs at an edge when the head is valid and the ready input of its class is high.
  - The head is popped: head increments modulo DEPTH and count decrements.
  - The head fields are registered into iss_*, with any CDB match in that same cycle applied to the issued operands.
  - The matching *_en is 1 for exactly the next cycle.
  - Otherwise all *_en are 0 and the iss_* fields hold their values.
- No bypass into issue:
  - An entry enqueued at edge k can issue at edge k+1 at the earliest.
  - Minimum latency from the enqueue handshake to the *_en pulse is 2 cycles.
- Strictly in-order: a stalled head blocks every younger entry, even when a younger entry's station is ready.
- Simultaneous enqueue and issue in one edge: count is unchanged; pointers both advance.
- Full: enq_ready is low even if the head issues in that cycle; there is no pass-through when full.
- Empty: no issue, *_en stays 0, iss_* fields hold.
- Pointer wrap: head and tail wrap from DEPTH-1 to 0; count alone distinguishes full from empty.
- Issue does not wait for operand readiness: entries are issued with tags still pending, and the station resolves them.
- A CDB tag of 0 is ignored.
- Priority: rst > flush > issue/enqueue.

Test Plan:
- Reset, then enqueue ALU op (tags 0, data_o=5, data_t=7) with alu_ready=1 -> alu_en pulses 2 cycles after the handshake; iss_data_o=5, iss_data_t=7; count returns to 0.
- Enqueue a Branch entry with tag_o=3 and hold br_ready=0; pulse cdb_valid[1] with tag=3, data=0xDEAD; then raise br_ready -> br_en=1, iss_tag_o=0, iss_data_o=0xDEAD.
- Enqueue a tag_t=4 entry in the same cycle that CDB channel 0 broadcasts tag 4 with value 9 -> stored and issued with tag_t=0, data_t=9.
- Fill 8 entries with ls_ready=0 -> enq_ready=0 and count=8; one extra enq_valid is not accepted; then set ls_ready=1 -> eight consecutive ls_en pulses in order, head wraps, count reaches 0.
- Queue LS head then ALU entry; ls_ready=0, alu_ready=1 -> no issue at all (in-order block); release ls_ready -> ls_en, then alu_en on the next cycle.
- With 5 entries queued, assert flush together with enq_valid -> next cycle count=0, all *_en=0, the flushed enqueue never issues; a new entry afterward issues normally.
